// File: rtl/ulaplus_colorizer.sv
// ulaplus_colorizer
//   Read-side consumer of the ULAplus palette RAM. Turns ZX bitmap and
//   attribute bytes into 3:3:3 RGB, one pixel per ck_pix.
//
//   Pipeline:
//     stage A - the character being fetched: attribute, bitmap and the two
//               palette entries (ink/paper) read through read_addr1/2.
//     stage B - the character being displayed: shifted out MSB first.
//   A character moves A -> B on every load, so a byte appears on rgb one
//   character (8 pixels) plus one clk28 after it was loaded.
//
//   Optional build macro ULAPLUS_BORDER_EN: while no character fetch is in
//   progress, slot 1 looks up the border colour in the palette, and border
//   pixels in ULAplus mode use that entry instead of the classic colour.
module ulaplus_colorizer #(
  parameter int unsigned CAPTURE_DELAY = 4
) (
  input  logic       rst_n,
  input  logic       clk28,
  input  logic       ck_pix,
  input  logic       load,
  input  logic [7:0] pix,
  input  logic [7:0] attr,
  input  logic       border,
  input  logic [2:0] border_color,
  input  logic       flash,
  input  logic       active,
  output logic [5:0] read_addr1,
  input  logic [7:0] read_data1,
  output logic [5:0] read_addr2,
  input  logic [7:0] read_data2,
  output logic [2:0] r,
  output logic [2:0] g,
  output logic [2:0] b,
  output logic       stale
);

  localparam int CW = $clog2(CAPTURE_DELAY + 1);
  localparam logic [CW-1:0] CAP_MAX  = CW'(CAPTURE_DELAY);
  localparam logic [CW-1:0] CAP_LAST = CW'(CAPTURE_DELAY - 1);

  // Palette entry layout is GGGRRRBB; blue is widened by OR-ing its two bits.
  function automatic logic [8:0] palette_rgb(input logic [7:0] e);
    return {e[4:2], e[7:5], e[1:0], e[1] | e[0]};
  endfunction

  // Classic ZX colour: index bits are G,R,B; every set channel gets lvl.
  function automatic logic [8:0] classic_rgb(input logic [2:0] grb, input logic [2:0] lvl);
    return {grb[1] ? lvl : 3'b000, grb[2] ? lvl : 3'b000, grb[0] ? lvl : 3'b000};
  endfunction

  // Stage A (fetch)
  logic [7:0]    r_attr_a;
  logic [7:0]    r_pix_a;
  logic [7:0]    r_ink_a;
  logic [7:0]    r_paper_a;
  logic          r_valid_a;
  logic [CW-1:0] r_cap_cnt;

  // Stage B (display)
  logic [7:0]    r_attr_b;
  logic [7:0]    r_ink_b;
  logic [7:0]    r_paper_b;
  logic [7:0]    r_sh_b;
  logic          r_valid_b;

  // Output side
  logic [5:0]    r_addr1;
  logic [5:0]    r_addr2;
  logic          r_stale;
  logic          r_pix_en;
  logic          r_border_s;
  logic [2:0]    r_bcol_s;
  logic [2:0]    r_r;
  logic [2:0]    r_g;
  logic [2:0]    r_b;

  logic          w_cap_busy;
  logic          w_load_a;
  logic [5:0]    w_ink_addr;
  logic [5:0]    w_paper_addr;
  logic [5:0]    w_addr1_next;
  logic          w_bit;
  logic          w_swap;
  logic [2:0]    w_idx;
  logic [2:0]    w_lvl;
  logic [7:0]    w_entry;
  logic [8:0]    w_rgb_next;

  // The fetch is in progress until the counter reaches CAPTURE_DELAY.
  assign w_cap_busy   = (r_cap_cnt < CAP_MAX);
  // Border characters carry no bitmap, so they do not restart the fetch.
  assign w_load_a     = load & ~border;
  assign w_ink_addr   = {r_attr_a[7:6], 1'b0, r_attr_a[2:0]};
  assign w_paper_addr = {r_attr_a[7:6], 1'b1, r_attr_a[5:3]};

`ifdef ULAPLUS_BORDER_EN
  // Slot 1 is lent to the border lookup whenever no character fetch needs it.
  assign w_addr1_next = w_cap_busy ? w_ink_addr : {2'b00, 1'b1, border_color};
`else
  assign w_addr1_next = w_ink_addr;
`endif

  // Stage A: take a new character on load, then count down the RAM read
  // window and latch both palette entries when it closes. The count starts
  // at the stage A load, so it includes the address register stage.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      r_attr_a  <= 8'h00;
      r_pix_a   <= 8'h00;
      r_ink_a   <= 8'h00;
      r_paper_a <= 8'h00;
      r_valid_a <= 1'b0;
      r_cap_cnt <= CAP_MAX;
    end else if (w_load_a) begin
      r_attr_a  <= attr;
      r_pix_a   <= pix;
      r_valid_a <= 1'b0;
      r_cap_cnt <= '0;
    end else if (w_cap_busy) begin
      r_cap_cnt <= r_cap_cnt + 1'b1;
      if (r_cap_cnt == CAP_LAST) begin
        r_ink_a   <= read_data1;
        r_paper_a <= read_data2;
        r_valid_a <= 1'b1;
      end
    end
  end

  // Palette addresses follow stage A one clk28 later.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      r_addr1 <= 6'd0;
      r_addr2 <= 6'd0;
    end else begin
      r_addr1 <= w_addr1_next;
      r_addr2 <= w_paper_addr;
    end
  end

  // Stage B: on load take the pre-load stage A contents; a load that cuts
  // the fetch short marks the character invalid. Otherwise shift per pixel.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      r_attr_b  <= 8'h00;
      r_ink_b   <= 8'h00;
      r_paper_b <= 8'h00;
      r_sh_b    <= 8'h00;
      r_valid_b <= 1'b0;
    end else if (load) begin
      r_attr_b  <= r_attr_a;
      r_ink_b   <= r_ink_a;
      r_paper_b <= r_paper_a;
      r_sh_b    <= r_pix_a;
      r_valid_b <= r_valid_a & ~w_cap_busy;
    end else if (ck_pix) begin
      r_sh_b    <= {r_sh_b[6:0], 1'b0};
    end
  end

  // Flag a load that arrived before the palette read window had closed.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      r_stale <= 1'b0;
    end else begin
      r_stale <= load & w_cap_busy;
    end
  end

  // Remember the pixel strobe and the border state sampled with it.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      r_pix_en   <= 1'b0;
      r_border_s <= 1'b0;
      r_bcol_s   <= 3'd0;
    end else begin
      r_pix_en <= ck_pix;
      if (ck_pix) begin
        r_border_s <= border;
        r_bcol_s   <= border_color;
      end
    end
  end

`ifdef ULAPLUS_BORDER_EN
  logic [CW-1:0] r_bcnt;
  logic [7:0]    r_border_c;

  // Border entry capture: restart whenever slot 1 is busy with a character
  // or its address is about to move, latch once it has been stable long enough.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      r_bcnt     <= '0;
      r_border_c <= 8'h00;
    end else if (w_cap_busy || (w_addr1_next != r_addr1)) begin
      r_bcnt     <= '0;
    end else if (r_bcnt < CAP_MAX) begin
      r_bcnt <= r_bcnt + 1'b1;
      if (r_bcnt == CAP_LAST) begin
        r_border_c <= read_data1;
      end
    end
  end
`endif

  assign w_bit   = r_sh_b[7];
  assign w_swap  = r_attr_b[7] & flash;
  assign w_idx   = (w_bit ^ w_swap) ? r_attr_b[2:0] : r_attr_b[5:3];
  assign w_lvl   = r_attr_b[6] ? 3'b111 : 3'b101;
  assign w_entry = w_bit ? r_ink_b : r_paper_b;

  // Colour of the current pixel: border, palette entry or classic mapping.
  always_comb begin
    w_rgb_next = 9'd0;
    if (r_border_s) begin
`ifdef ULAPLUS_BORDER_EN
      if (active) begin
        w_rgb_next = palette_rgb(r_border_c);
      end else begin
        w_rgb_next = classic_rgb(r_bcol_s, 3'b101);
      end
`else
      w_rgb_next = classic_rgb(r_bcol_s, 3'b101);
`endif
    end else if (active) begin
      // A character whose fetch was cut short is blanked entirely.
      if (r_valid_b) begin
        w_rgb_next = palette_rgb(w_entry);
      end
    end else begin
      w_rgb_next = classic_rgb(w_idx, w_lvl);
    end
  end

  // RGB register advances one clk28 after each pixel strobe.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      r_r <= 3'd0;
      r_g <= 3'd0;
      r_b <= 3'd0;
    end else if (r_pix_en) begin
      r_r <= w_rgb_next[8:6];
      r_g <= w_rgb_next[5:3];
      r_b <= w_rgb_next[2:0];
    end
  end

  assign read_addr1 = r_addr1;
  assign read_addr2 = r_addr2;
  assign r          = r_r;
  assign g          = r_g;
  assign b          = r_b;
  assign stale      = r_stale;

endmodule

// File: doc/ulaplus_colorizer.md
Name: ulaplus_colorizer

Overview:
- Palette read-side consumer for the ULAplus palette RAM. It turns ZX pixel/attribute bytes into 3:3:3 RGB.
- Generates ink/paper palette addresses per character cell on read_addr1/read_addr2 and captures the returned entries.
- Shifts pixels out at the pixel rate.
- Falls back to the classic ZX colour mapping when ULAplus is inactive.

Parameters:
- CAPTURE_DELAY, 4: clk28 cycles from address change to palette data capture; covers the 2-phase time-multiplexed RAM read.

Ports:
- rst_n  input  1  asynchronous, active-low reset
- clk28  input  1  system clock, 28 MHz
- ck_pix  input  1  pixel enable, one clk28 cycle wide, every 4th cycle
- load  input  1  character boundary; coincides with a ck_pix cycle
- pix  input  8  bitmap byte, MSB first
- attr  input  8  attribute: [7] flash, [6] bright, [5:3] paper, [2:0] ink
- border  input  1  current output pixel is border; sampled on ck_pix
- border_color  input  3  border colour, GRB
- flash  input  1  flash phase
- active  input  1  ULAplus mode enable from the palette block
- read_addr1  output  6  palette address, slot 1
- read_data1  input  8  palette data, slot 1
- read_addr2  output  6  palette address, slot 2
- read_data2  input  8  palette data, slot 2
- r, g, b  output  3 each  colour out
- stale  output  1  one-clk28 pulse on a capture-window violation

Behaviour:
- Reset values:
  - all outputs 0
  - stage A/B registers 0
  - cap_cnt = CAPTURE_DELAY (idle)
  - validB = 0
- Stage A:
  - On a load with !border: attrA <= attr, pixA <= pix, cap_cnt <= 0.
- Address outputs:
  - Registered; updated the edge after stage A changes.
  - read_addr1 = {attrA[7:6], 0, attrA[2:0]} (ink).
  - read_addr2 = {attrA[7:6], 1, attrA[5:3]} (paper).
- Capture:
  - cap_cnt increments per clk28 while below CAPTURE_DELAY (cap_busy).
  - On reaching CAPTURE_DELAY: inkA <= read_data1, paperA <= read_data2, validA <= 1.
- Transfer on load:
  - Stage B <= stage A, using pre-load A values (read-before-write in the same cycle).
  - shB <= pixA, validB <= validA.
  - Then A reloads, and validA <= 0 until its new capture completes.
- Capture-window violation:
  - If load arrives while cap_busy, validB = 0 and stale pulses for 1 cycle.
  - In ULAplus mode the whole character outputs r=g=b=0.
- Shifting:
  - On non-load ck_pix: shB <= shB << 1.
  - Current bit = shB[7]. rgb register updates the clk28 edge after each ck_pix.
  - Latency from load of a byte to its first pixel on rgb: one character (8 ck_pix) + 1 clk28.
- Colour selection, with sel = current bit ? ink : paper:
  - active=1:
    - entry e = sel entry.
    - g = e[7:5], r = e[4:2], b = {e[1:0], e[1]|e[0]}.
    - No flash swap.
  - active=0:
    - Colour index is attr ink[2:0] or paper[5:3] (GRB).
    - If attrB[7] && flash, ink and paper are swapped.
    - Channel level = attrB[6] ? 3'b111 : 3'b101 when the bit is set, else 0.
- Border pixels: classic colour from border_color, bright off (level 101).
- active changes mid-character take effect on the next pixel.
- Reset mid-operation: immediate return to reset values; the first character after reset outputs black in ULAplus mode (validB=0).

Optional Feature:
- Macro: ULAPLUS_BORDER_EN.
- Defined:
  - When !cap_busy, read_addr1 = {00, 1, border_color}.
  - A separate counter captures border_c <= read_data1 CAPTURE_DELAY cycles after the last border address change with no intervening cap_busy.
  - Border pixels with active=1 use border_c, decoded as a palette entry.
- Undefined: border is always classic colour; read_addr1 holds the ink address.

Test Plan:
- Classic mapping: active=0, attr=0x47, pix=0xF0, flash=0 -> first 4 pixels rgb=7/7/7, next 4 rgb=0/0/0, one character after load.
- ULAplus palette lookup: active=1, attr=0x8A, model palette[0x22]=0xE3, palette[0x29]=0x1C, pix=0x80:
  - read_addr1 = 0x22, read_addr2 = 0x29.
  - Pixel 0: g=7, r=0, b=7.
  - Pixels 1-7: g=0, r=7, b=0.
- Flash swap: active=0, attr=0xC2, pix=0xFF:
  - flash=0 -> r=7, others 0.
  - flash=1 -> all 0 (paper 0).
- Capture-window violation: active=1, two loads 2 clk28 apart -> stale=1 for one cycle; the affected character outputs rgb=0 throughout.
- Border: border=1, border_color=5, palette[0x0D]=0x1C:
  - ULAPLUS_BORDER_EN defined, active=1 -> r=7, g=0, b=0.
  - Undefined -> g=5, r=0, b=5.
- Reset mid-character: assert rst_n=0 during shifting -> rgb, read_addr1/2 = 0 immediately; the first character after release outputs black with active=1.
